event_stretcher: RTL

- Output-side counterpart to the team's switch debouncer. The debouncer turns a slow, noisy human input into a clean logic level; this block turns fast single-cycle logic events into slow, human-visible LED blinks.
- Every accepted event produces one LED "on" window of fixed length, followed by a mandatory "off" gap, so back-to-back events stay distinguishable by eye.
- Events arriving while a blink is in progress are queued in a saturating pending counter.
- Sits between core logic (e.g. debounced-button edge detectors) and board LEDs.

---
 rtl/event_stretcher.sv | 119 +++++++++++
 1 files changed

// File: rtl/event_stretcher.sv
// event_stretcher: turns single-cycle events into fixed on/off LED blinks.
// Define EVENT_STRETCHER_QUEUE_EN to queue events that arrive mid-blink.
module event_stretcher #(
  parameter int N         = 20,
  parameter int ON_TICKS  = 3,
  parameter int OFF_TICKS = 3,
  parameter int PEND_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              event_in,
  input  logic              ovf_clr,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    GAP
  } state_t;

  localparam logic [7:0] ON_LAST  = 8'(ON_TICKS - 1);
  localparam logic [7:0] OFF_LAST = 8'(OFF_TICKS - 1);

  state_t       state;
  state_t       nxt_state;
  logic [N-1:0] presc;
  logic [7:0]   phase;
  logic         tick;
  logic         on_done;
  logic         gap_done;
  logic         pend_nz;
  logic         pend_full;
  logic         queue_ev;
  logic         pend_inc;
  logic         pend_dec;
  logic         drop;

  assign tick     = &presc;
  assign on_done  = tick && (phase == ON_LAST);
  assign gap_done = tick && (phase == OFF_LAST);

`ifdef EVENT_STRETCHER_QUEUE_EN
  logic [PEND_W-1:0] pend_q;
  assign pend_nz   = |pend_q;
  assign pend_full = &pend_q;
  assign pending   = pend_q;
`else
  // Without a queue every mid-blink event is a drop.
  assign pend_nz   = 1'b0;
  assign pend_full = 1'b1;
  assign pending   = '0;
`endif

  always_comb begin
    nxt_state = state;
    queue_ev  = 1'b0;
    pend_dec  = 1'b0;
    unique case (state)
      IDLE: begin
        if (event_in || pend_nz) begin
          nxt_state = ON;
          pend_dec  = pend_nz && !event_in;
        end
      end
      ON: begin
        if (on_done) nxt_state = GAP;
        queue_ev = event_in;
      end
      GAP: begin
        if (gap_done && pend_nz) begin
          nxt_state = ON;
          pend_dec  = !event_in;
        end else begin
          if (gap_done) nxt_state = IDLE;
          queue_ev = event_in;
        end
      end
      default: nxt_state = IDLE;
    endcase
    pend_inc = queue_ev && !pend_full;
    drop     = queue_ev && pend_full;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      presc    <= '0;
      phase    <= '0;
      led      <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
`ifdef EVENT_STRETCHER_QUEUE_EN
      pend_q   <= '0;
`endif
    end else begin
      state <= nxt_state;
      led   <= (nxt_state == ON);
      busy  <= (nxt_state != IDLE);
      if (nxt_state != state) begin
        presc <= '0;
        phase <= '0;
      end else begin
        presc <= presc + 1'b1;
        if (tick && phase != 8'hff) phase <= phase + 8'd1;
      end
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
`ifdef EVENT_STRETCHER_QUEUE_EN
      if (pend_inc)      pend_q <= pend_q + 1'b1;
      else if (pend_dec) pend_q <= pend_q - 1'b1;
`endif
    end
  end

endmodule
